// File: rtl/multi_ch_timer.sv
// Multi-channel programmable timer: CH independent channels, each with a period
// register, periodic/one-shot mode, pausable count, overflow pulse and sticky flag.
module multi_ch_timer #(
   parameter int BITS       = 32,
   parameter int CH         = 4,
   parameter int DEF_PERIOD = 40000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [CH-1:0]      start,
   input  logic [CH-1:0]      stop,
   input  logic [CH-1:0]      enable,
   input  logic [CH-1:0]      mode,
   input  logic [CH-1:0]      load,
   input  logic [CH*BITS-1:0] load_val,
   input  logic [CH-1:0]      clr_flag,
   output logic [CH-1:0]      overflow,
   output logic [CH-1:0]      ovf_flag,
   output logic [CH-1:0]      busy,
   output logic [CH*BITS-1:0] cnt_val
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [BITS-1:0] DEF_P = BITS'(DEF_PERIOD);
   localparam logic [BITS-1:0] ONE   = BITS'(1);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      state_t          state, state_n;
      logic [BITS-1:0] cnt, cnt_n;
      logic [BITS-1:0] period, period_n;
      logic [BITS-1:0] last;
      logic            mode_q, mode_n;
      logic            ovf_q, ovf_n;
      logic            flag_q;

      // A period of zero behaves like a period of one: terminal count at cnt 0.
      assign last = (period == '0) ? '0 : period - ONE;

      // Priority: load, stop, start, count.
      always_comb begin
         state_n  = state;
         cnt_n    = cnt;
         period_n = period;
         mode_n   = mode_q;
         ovf_n    = 1'b0;
         if (load[i]) begin
            period_n = load_val[i*BITS +: BITS];
            cnt_n    = '0;
            state_n  = IDLE;
         end else if (stop[i]) begin
            cnt_n   = '0;
            state_n = IDLE;
         end else if (start[i] && state != RUN) begin
            mode_n  = mode[i];
            cnt_n   = '0;
            state_n = RUN;
         end else if (state == RUN && enable[i]) begin
            if (cnt == last) begin
               cnt_n = '0;
               ovf_n = 1'b1;
               if (mode_q) state_n = DONE;
            end else begin
               cnt_n = cnt + ONE;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            period <= DEF_P;
            mode_q <= 1'b0;
            ovf_q  <= 1'b0;
            flag_q <= 1'b0;
         end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            period <= period_n;
            mode_q <= mode_n;
            ovf_q  <= ovf_n;
            // Set wins over a same-cycle clear.
            flag_q <= ovf_n | (flag_q & ~clr_flag[i]);
         end
      end

      assign overflow[i]              = ovf_q;
      assign ovf_flag[i]              = flag_q;
      assign busy[i]                  = (state == RUN);
      assign cnt_val[i*BITS +: BITS]  = cnt;
   end

endmodule
